// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared audio-unit constants, beat word type and loader states
package apu_pkg;

    localparam int ADDR_W = 10;
    localparam int TONE_W = 4;
    localparam int VOICES = 4;
    localparam int BEAT_W = VOICES * TONE_W;

    // One beat word: voice 0 occupies the most significant nibble
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        LD_IDLE    = 2'd0,
        LD_COLLECT = 2'd1,
        LD_WRITE   = 2'd2,
        LD_DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs VOICES consecutive tone codes into one beat word
module beat_packer #(
    parameter int TONE_W = apu_pkg::TONE_W,
    parameter int VOICES = apu_pkg::VOICES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       shift_en,
    input  logic [TONE_W-1:0]          nibble,
    output logic [VOICES*TONE_W-1:0]   word,
    output logic                       word_ready
);

    localparam int BEAT_W = VOICES * TONE_W;
    localparam int CNT_W  = (VOICES > 1) ? $clog2(VOICES) : 1;

    logic [BEAT_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;

    // The word including the code being accepted now, so the loader can
    // latch a complete beat on the same edge as the final handshake.
    assign word       = {sr[BEAT_W-TONE_W-1:0], nibble};
    assign word_ready = shift_en & (cnt == CNT_W'(VOICES - 1));

    // Shift codes in from the LSB end; counter wraps after VOICES codes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= word;
            cnt <= (cnt == CNT_W'(VOICES - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/beat_loader.sv
// rtl/beat_loader.sv - streams tone codes into beat BRAM port B over an address range
module beat_loader
    import apu_pkg::*;
#(
    parameter int ADDR_W = apu_pkg::ADDR_W,
    parameter int TONE_W = apu_pkg::TONE_W,
    parameter int VOICES = apu_pkg::VOICES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [ADDR_W-1:0]          start_addr,
    input  logic [ADDR_W-1:0]          end_addr,
    input  logic [TONE_W-1:0]          tone_in,
    input  logic                       tone_valid,
    output logic                       tone_ready,
    output logic [ADDR_W-1:0]          addr_b,
    output logic [VOICES*TONE_W-1:0]   data_b,
    output logic                       we_b,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ADDR_W:0]            beat_count
);

    localparam int BEAT_W = VOICES * TONE_W;

    loader_state_t     state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_q;
    logic              shift_en;
    logic              packer_clr;
    logic              word_ready;
    logic [BEAT_W-1:0] packed_word;

    // Status strobes decode straight from state so reset clears them at once
    assign tone_ready = (state == LD_COLLECT);
    assign we_b       = (state == LD_WRITE);
    assign done       = (state == LD_DONE);
    assign busy       = (state != LD_IDLE);

    // Abort wins over a same-cycle handshake, so the code is left unconsumed
    assign shift_en   = tone_valid & tone_ready & ~abort;
    // Holding the packer clear while idle guarantees each load starts on voice 0
    assign packer_clr = (state == LD_IDLE) | abort;

    beat_packer #(
        .TONE_W (TONE_W),
        .VOICES (VOICES)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clr        (packer_clr),
        .shift_en   (shift_en),
        .nibble     (tone_in),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    // Load sequencer: range capture, word write-out, pointer and beat counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= LD_IDLE;
            ptr        <= '0;
            end_q      <= '0;
            addr_b     <= '0;
            data_b     <= '0;
            beat_count <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                LD_IDLE: begin
                    if (start) begin
                        if (start_addr <= end_addr) begin
                            ptr        <= start_addr;
                            end_q      <= end_addr;
                            beat_count <= '0;
                            error      <= 1'b0;
                            state      <= LD_COLLECT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LD_COLLECT: begin
                    if (abort) begin
                        state <= LD_IDLE;
                    end else if (word_ready) begin
                        // Address and data are presented for the whole WRITE cycle
                        addr_b     <= ptr;
                        data_b     <= packed_word;
                        beat_count <= beat_count + {{ADDR_W{1'b0}}, 1'b1};
                        state      <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    if (abort) begin
                        state <= LD_IDLE;
                    end else if (ptr == end_q) begin
                        // Stop at end_addr rather than incrementing, so ptr never wraps
                        state <= LD_DONE;
                    end else begin
                        ptr   <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        state <= LD_COLLECT;
                    end
                end
                LD_DONE: begin
                    state <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_loader.sv
// tb/tb_beat_loader.sv - directed self-checking bench for beat_loader
module tb_beat_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  start_addr = '0;
    logic [9:0]  end_addr = '0;
    logic [3:0]  tone_in = '0;
    logic        tone_valid = 1'b0;
    logic        tone_ready;
    logic [9:0]  addr_b;
    logic [15:0] data_b;
    logic        we_b;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] beat_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [9:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          done_cnt = 0;
    int          ready_in_write = 0;

    beat_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .tone_in    (tone_in),
        .tone_valid (tone_valid),
        .tone_ready (tone_ready),
        .addr_b     (addr_b),
        .data_b     (data_b),
        .we_b       (we_b),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            wr_addr.push_back(addr_b);
            wr_data.push_back(data_b);
            if (tone_ready === 1'b1) ready_in_write++;
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        ready_in_write = 0;
    endtask

    task automatic do_start(input logic [9:0] sa, input logic [9:0] ea);
        start_addr = sa;
        end_addr = ea;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_tone(input logic [3:0] c, input int gap);
        int t;
        if (gap > 0) begin
            tone_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        tone_in = c;
        tone_valid = 1'b1;
        t = 0;
        while (tone_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: got tone_ready=%0b expected 1 within 20 cycles", tone_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: got done=%0b expected 1", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tone_ready !== 1'b0) begin n_fail++; $display("FAIL rst_tone_ready: got %0b expected 0", tone_ready); end
        n_checks++; if (we_b !== 1'b0) begin n_fail++; $display("FAIL rst_we_b: got %0b expected 0", we_b); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %0b expected 0", error); end
        n_checks++; if (addr_b !== 10'd0) begin n_fail++; $display("FAIL rst_addr_b: got %0h expected 0", addr_b); end
        n_checks++; if (data_b !== 16'h0) begin n_fail++; $display("FAIL rst_data_b: got %0h expected 0", data_b); end
        n_checks++; if (beat_count !== 11'd0) begin n_fail++; $display("FAIL rst_beat_count: got %0d expected 0", beat_count); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_busy: got %0b expected 0", busy); end
    endtask

    task automatic test_single_word();
        clear_mon();
        do_start(10'd5, 10'd5);
        n_checks++; if (tone_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after_start: got %0b expected 1", tone_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b expected 1", busy); end
        for (int i = 1; i <= 4; i++) send_tone(4'(i), 0);
        tone_valid = 1'b0;
        n_checks++; if (we_b !== 1'b1) begin n_fail++; $display("FAIL single_we_b: got %0b expected 1", we_b); end
        n_checks++; if (addr_b !== 10'd5) begin n_fail++; $display("FAIL single_addr_b: got %0h expected 5", addr_b); end
        n_checks++; if (data_b !== 16'h1234) begin n_fail++; $display("FAIL single_data_b: got %0h expected 1234", data_b); end
        n_checks++; if (tone_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_in_write: got %0b expected 0", tone_ready); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %0b expected 1", done); end
        n_checks++; if (we_b !== 1'b0) begin n_fail++; $display("FAIL single_we_b_low: got %0b expected 0", we_b); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %0b expected 0", busy); end
        n_checks++; if (beat_count !== 11'd1) begin n_fail++; $display("FAIL single_beat_count: got %0d expected 1", beat_count); end
        n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL single_write_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (data_b !== 16'h1234) begin n_fail++; $display("FAIL single_data_hold: got %0h expected 1234", data_b); end
    endtask

    task automatic test_multi_gaps();
        logic [3:0]  codes[12] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        int          gaps[12]  = '{0, 2, 1, 0, 3, 0, 0, 1, 2, 0, 0, 1};
        logic [15:0] exp_data[3] = '{16'hABCD, 16'hEF01, 16'h2345};
        clear_mon();
        do_start(10'd0, 10'd2);
        for (int i = 0; i < 12; i++) send_tone(codes[i], gaps[i]);
        tone_valid = 1'b0;
        wait_done();
        n_checks++; if (wr_addr.size() !== 3) begin n_fail++; $display("FAIL multi_write_count: got %0d expected 3", wr_addr.size()); end
        for (int w = 0; w < 3 && w < wr_addr.size(); w++) begin
            n_checks++; if (wr_addr[w] !== 10'(w)) begin n_fail++; $display("FAIL multi_addr%0d: got %0h expected %0h", w, wr_addr[w], w); end
            n_checks++; if (wr_data[w] !== exp_data[w]) begin n_fail++; $display("FAIL multi_data%0d: got %0h expected %0h", w, wr_data[w], exp_data[w]); end
        end
        n_checks++; if (ready_in_write !== 0) begin n_fail++; $display("FAIL multi_ready_in_write: got %0d expected 0", ready_in_write); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (beat_count !== 11'd3) begin n_fail++; $display("FAIL multi_beat_count: got %0d expected 3", beat_count); end
    endtask

    task automatic test_bad_range();
        clear_mon();
        do_start(10'd10, 10'd3);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error: got %0b expected 1", error); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy: got %0b expected 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error_sticky: got %0b expected 1", error); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL bad_no_write: got %0d expected 0", wr_addr.size()); end
        do_start(10'd0, 10'd0);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL bad_error_cleared: got %0b expected 0", error); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bad_restart_busy: got %0b expected 1", busy); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_abort_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_abort();
        clear_mon();
        do_start(10'd0, 10'd3);
        for (int i = 0; i < 4; i++) send_tone(4'(i + 7), 0);
        tone_valid = 1'b0;
        do_start(10'd7, 10'd9);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_start_ignored_busy: got %0b expected 1", busy); end
        send_tone(4'h1, 0);
        send_tone(4'h2, 0);
        tone_in = 4'h6;
        tone_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tone_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %0b expected 0", busy); end
        n_checks++; if (tone_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %0b expected 0", tone_ready); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL abort_write_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (wr_addr.size() > 0 && wr_data[0] !== 16'h789A) begin n_fail++; $display("FAIL abort_first_data: got %0h expected 789a", wr_data[0]); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
        n_checks++; if (beat_count !== 11'd1) begin n_fail++; $display("FAIL abort_beat_count: got %0d expected 1", beat_count); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL abort_error: got %0b expected 0", error); end
        clear_mon();
        do_start(10'd8, 10'd8);
        for (int i = 1; i <= 4; i++) send_tone(4'(i), 0);
        tone_valid = 1'b0;
        wait_done();
        n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL abort_reload_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (wr_addr.size() > 0 && (wr_addr[0] !== 10'd8 || wr_data[0] !== 16'h1234)) begin
            n_fail++; $display("FAIL abort_reload_word: got %0h@%0h expected 1234@8", wr_data[0], wr_addr[0]);
        end
    endtask

    task automatic test_full_range();
        int          bad_addr;
        int          bad_data;
        logic [3:0]  base;
        logic [15:0] exp;
        clear_mon();
        do_start(10'd0, 10'd1023);
        for (int i = 0; i < 4096; i++) send_tone(4'(i), 0);
        tone_valid = 1'b0;
        wait_done();
        n_checks++; if (wr_addr.size() !== 1024) begin n_fail++; $display("FAIL full_write_count: got %0d expected 1024", wr_addr.size()); end
        bad_addr = 0;
        bad_data = 0;
        for (int w = 0; w < wr_addr.size(); w++) begin
            base = 4'((w % 4) * 4);
            exp = {base, base + 4'd1, base + 4'd2, base + 4'd3};
            if (wr_addr[w] !== 10'(w)) bad_addr++;
            if (wr_data[w] !== exp) bad_data++;
        end
        n_checks++; if (bad_addr !== 0) begin n_fail++; $display("FAIL full_addr_sequence: got %0d bad expected 0", bad_addr); end
        n_checks++; if (bad_data !== 0) begin n_fail++; $display("FAIL full_data: got %0d bad expected 0", bad_data); end
        n_checks++; if (addr_b !== 10'd1023) begin n_fail++; $display("FAIL full_last_addr: got %0d expected 1023", addr_b); end
        n_checks++; if (beat_count !== 11'd1024) begin n_fail++; $display("FAIL full_beat_count: got %0d expected 1024", beat_count); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_load();
        clear_mon();
        do_start(10'd0, 10'd3);
        for (int i = 0; i < 4; i++) send_tone(4'hF, 0);
        tone_valid = 1'b0;
        n_checks++; if (we_b !== 1'b1) begin n_fail++; $display("FAIL rml_in_write: got %0b expected 1", we_b); end
        reset = 1'b0;
        #1;
        n_checks++; if ({tone_ready, we_b, busy, done, error} !== 5'b0) begin
            n_fail++; $display("FAIL rml_strobes: got %05b expected 00000", {tone_ready, we_b, busy, done, error});
        end
        n_checks++; if ({addr_b, data_b, beat_count} !== 37'd0) begin
            n_fail++; $display("FAIL rml_values: got addr %0h data %0h count %0d expected 0", addr_b, data_b, beat_count);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rml_idle: got %0b expected 0", busy); end
        n_checks++; if (tone_ready !== 1'b0) begin n_fail++; $display("FAIL rml_ready: got %0b expected 0", tone_ready); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL rml_no_write: got %0d expected 0", wr_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_gaps();
        test_bad_range();
        test_abort();
        test_full_range();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
